// File: rtl/stream_deserializer_if.sv
// Handshake bundle for stream_deserializer: narrow beat stream in, wide word stream out.
// The design sits on the slave modport; whoever feeds and drains it uses master.
interface stream_deserializer_if #(
    parameter int Nbeats = 4,
    parameter int Nbits  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [Nbits-1:0]        in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [Nbeats*Nbits-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_deserializer.sv
// Collects Nbeats narrow beats into one wide word; assembly and output registers are
// separate so a new word can be gathered while the previous one waits downstream.
module stream_deserializer #(
    parameter int Nbeats = 4,
    parameter int Nbits  = 8
) (
    input  logic           clk,
    input  logic           reset,
    stream_deserializer_if.slave bus
);
    localparam int CNT_W = (Nbeats > 1) ? $clog2(Nbeats) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(Nbeats - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic                    r_out_valid;
    logic [Nbeats*Nbits-1:0] r_out_data;
    logic [Nbeats*Nbits-1:0] w_word;
    logic                    w_last;
    logic                    w_in_ready;
    logic                    w_in_fire;
    logic                    w_out_fire;

    assign w_last     = (r_cnt == LAST);
    // Only the final beat can stall; it may enter when the output slot drains this cycle.
    assign w_in_ready = !w_last || !r_out_valid || bus.out_ready;
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

    generate
        if (Nbeats > 1) begin : g_asm
            logic [(Nbeats-1)*Nbits-1:0] r_asm;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_asm <= '0;
                end else if (w_in_fire && !w_last) begin
                    for (int i = 0; i < Nbeats - 1; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            r_asm[i*Nbits +: Nbits] <= bus.in_data;
                        end
                    end
                end
            end

            // The final beat goes straight into the top slice, never via the assembly register.
            assign w_word = {bus.in_data, r_asm};
        end else begin : g_noasm
            assign w_word = bus.in_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_in_fire) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_in_fire && w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_deserializer.sv
// Directed bench for stream_deserializer: a 4x8 instance for the main scenarios and a
// 1x16 instance for the single-beat case.
module tb_stream_deserializer;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    stream_deserializer_if #(.Nbeats(4), .Nbits(8))  bus0 ();
    stream_deserializer_if #(.Nbeats(1), .Nbits(16)) bus1 ();

    stream_deserializer #(.Nbeats(4), .Nbits(8)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    stream_deserializer #(.Nbeats(1), .Nbits(16)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        tick();
    endtask

    task automatic idle();
        bus0.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = '0;
        bus0.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;

        // Reset state
        #3;
        chk_eq("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk_eq("rst_out_data",  bus0.out_data,       32'h0);
        chk_eq("rst_in_ready",  32'(bus0.in_ready),  32'd1);
        chk_eq("rst1_out_valid", 32'(bus1.out_valid), 32'd0);
        #19 reset = 1'b0;
        tick();

        // 1: single word, out_ready high
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 8'((i + 1) * 8'h11);
            #1 chk_eq("t1_in_ready", 32'(bus0.in_ready), 32'd1);
            if (i < 3) chk_eq("t1_no_early", 32'(bus0.out_valid), 32'd0);
            tick();
        end
        chk_eq("t1_out_valid", 32'(bus0.out_valid), 32'd1);
        chk_eq("t1_out_data",  bus0.out_data,       32'h44332211);
        idle();
        chk_eq("t1_valid_once", 32'(bus0.out_valid), 32'd0);

        // 2: eight beats back-to-back
        for (int i = 1; i <= 8; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 8'(i);
            #1 chk_eq("t2_in_ready", 32'(bus0.in_ready), 32'd1);
            tick();
            if (i == 4) begin
                chk_eq("t2_w1_valid", 32'(bus0.out_valid), 32'd1);
                chk_eq("t2_w1_data",  bus0.out_data,       32'h04030201);
            end
            if (i == 5) chk_eq("t2_w1_drained", 32'(bus0.out_valid), 32'd0);
        end
        chk_eq("t2_w2_valid", 32'(bus0.out_valid), 32'd1);
        chk_eq("t2_w2_data",  bus0.out_data,       32'h08070605);
        idle();
        chk_eq("t2_drained", 32'(bus0.out_valid), 32'd0);

        // 3: backpressure on the final beat
        bus0.out_ready = 1'b0;
        beat(8'hC1); beat(8'hC2); beat(8'hC3); beat(8'hC4);
        chk_eq("t3_old_valid", 32'(bus0.out_valid), 32'd1);
        chk_eq("t3_old_data",  bus0.out_data,       32'hC4C3C2C1);
        for (int i = 0; i < 3; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 8'(8'hA0 + i);
            #1 chk_eq("t3_nonfinal_ready", 32'(bus0.in_ready), 32'd1);
            tick();
        end
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'hA3;
        #1 chk_eq("t3_final_stall", 32'(bus0.in_ready), 32'd0);
        tick();
        chk_eq("t3_hold_valid", 32'(bus0.out_valid), 32'd1);
        chk_eq("t3_hold_data",  bus0.out_data,       32'hC4C3C2C1);
        chk_eq("t3_still_stall", 32'(bus0.in_ready), 32'd0);
        bus0.out_ready = 1'b1;
        #1 chk_eq("t3_comb_ready", 32'(bus0.in_ready), 32'd1);
        tick();
        chk_eq("t3_b2b_valid", 32'(bus0.out_valid), 32'd1);
        chk_eq("t3_b2b_data",  bus0.out_data,       32'hA3A2A1A0);
        idle();
        chk_eq("t3_drained", 32'(bus0.out_valid), 32'd0);

        // 4: gaps between beats
        beat(8'h01);
        for (int g = 0; g < 3; g++) begin
            idle();
            chk_eq("t4_gap_a", 32'(bus0.out_valid), 32'd0);
        end
        beat(8'h02);
        for (int g = 0; g < 3; g++) begin
            idle();
            chk_eq("t4_gap_b", 32'(bus0.out_valid), 32'd0);
        end
        beat(8'h03);
        chk_eq("t4_no_early", 32'(bus0.out_valid), 32'd0);
        beat(8'h04);
        chk_eq("t4_valid", 32'(bus0.out_valid), 32'd1);
        chk_eq("t4_data",  bus0.out_data,       32'h04030201);
        idle();

        // 5: async reset mid-word with a held output word
        bus0.out_ready = 1'b0;
        beat(8'hE1); beat(8'hE2); beat(8'hE3); beat(8'hE4);
        chk_eq("t5_held_valid", 32'(bus0.out_valid), 32'd1);
        beat(8'hD1); beat(8'hD2);
        bus0.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_eq("t5_rst_valid",  32'(bus0.out_valid), 32'd0);
        chk_eq("t5_rst_data",   bus0.out_data,       32'h0);
        chk_eq("t5_rst_ready",  32'(bus0.in_ready),  32'd1);
        #2 reset = 1'b0;
        bus0.out_ready = 1'b1;
        beat(8'hB1); beat(8'hB2); beat(8'hB3);
        chk_eq("t5_no_stale", 32'(bus0.out_valid), 32'd0);
        beat(8'hB4);
        chk_eq("t5_valid", 32'(bus0.out_valid), 32'd1);
        chk_eq("t5_data",  bus0.out_data,       32'hB4B3B2B1);
        idle();

        // 6: single-beat instance
        bus1.out_ready = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 16'hBEEF;
        #1 chk_eq("t6_ready_empty", 32'(bus1.in_ready), 32'd1);
        tick();
        chk_eq("t6_valid", 32'(bus1.out_valid), 32'd1);
        chk_eq("t6_data",  bus1.out_data,       32'h0000BEEF);
        bus1.in_data = 16'hCAFE;
        #1 chk_eq("t6_stall", 32'(bus1.in_ready), 32'd0);
        tick();
        chk_eq("t6_hold_data", bus1.out_data, 32'h0000BEEF);
        bus1.out_ready = 1'b1;
        #1 chk_eq("t6_comb_ready", 32'(bus1.in_ready), 32'd1);
        tick();
        chk_eq("t6_b2b_valid", 32'(bus1.out_valid), 32'd1);
        chk_eq("t6_b2b_data",  bus1.out_data,       32'h0000CAFE);
        bus1.in_valid = 1'b0;
        tick();
        chk_eq("t6_drained", 32'(bus1.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_deserializer.md
Name: stream_deserializer

Overview:
- Gathers Nbeats consecutive narrow beats from a valid/ready stream and emits them as one wide word on a valid/ready output.
- It is the receiving end of a sequencer + one_hot_mux serializer, which sends a wide word one beat at a time.
- Double-buffered (assembly register plus output register), so it accepts one input beat per cycle while the output drains.

Parameters:
- Nbeats, 4, beats per output word; must be >= 1.
- Nbits, 8, width of one input beat.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the input beat this cycle.
- in_data  input  Nbits  input beat.
- out_valid  output  1  output word present.
- out_ready  input  1  downstream accepts the output word this cycle.
- out_data  output  Nbeats*Nbits  assembled word; beat 0 in bits [Nbits-1:0], beat i in bits [(i+1)*Nbits-1 : i*Nbits].

Behaviour:
- Handshake terms:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Data transfers only on a fire, sampled at the rising edge.
- Reset, asynchronous, effective immediately:
  - beat counter cnt = 0, assembly register = 0.
  - out_valid = 0, out_data = 0.
  - in_ready follows its equation and is therefore 1 in reset.
- cnt is $clog2(Nbeats) bits, minimum 1 bit. It runs 0..Nbeats-1 and wraps to 0 after the final beat. It never holds a value >= Nbeats.
- in_ready = (cnt != Nbeats-1) | !out_valid | out_ready.
  - This is combinational. The out_ready -> in_ready path is intentional.
  - Non-final beats are always accepted.
  - The final beat stalls only while the output register is full and not draining this cycle.
- On in_fire with cnt < Nbeats-1:
  - assembly slice cnt <= in_data.
  - cnt <= cnt+1.
- On in_fire with cnt == Nbeats-1:
  - out_data <= {in_data, assembly slices Nbeats-2..0}.
  - out_valid <= 1.
  - cnt <= 0.
  - The assembly register is not cleared; stale content is overwritten by the next word.
- out_valid update rules:
  - On out_fire without a completing in_fire: out_valid <= 0, and out_data holds its value.
  - On out_fire together with a completing in_fire: out_valid stays 1 and out_data takes the new word (back-to-back).
  - No fire on either side: all state holds.
- Latency: the final beat accepted at edge k makes out_valid = 1 from edge k onward. There is no combinational in_data -> out_data path.
- Throughput: 1 beat per cycle sustained, 1 word per Nbeats cycles, when out_ready = 1.
- out_data must stay stable while out_valid = 1 and out_ready = 0.
- Nbeats = 1: degenerates to a single-entry registered stage. in_ready = !out_valid | out_ready.
- Reset asserted mid-word: the partial word is discarded and cnt returns to 0. A held output word is dropped.
- in_valid may deassert between beats with no effect on cnt or the assembly register.

Test Plan:
1. Reset, then stream 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles with out_ready = 1 -> out_valid = 1 for exactly one cycle after the 4th beat, out_data = 32'h44332211, in_ready = 1 throughout.
2. Continuous 8 beats 01..08 with out_ready = 1 -> words 32'h04030201 then 32'h08070605 with no input stall and no bubble between the final beat of word 1 and the first beat of word 2.
3. Complete a word with out_ready = 0, then offer 4 more beats A0..A3 -> A0..A2 accepted, in_ready = 0 at A3 while out_data stays at the old word. Raise out_ready -> in the same cycle A3 is accepted and the old word fires; next cycle out_data = 32'hA3A2A1A0.
4. Beats 01, 02 interleaved with in_valid = 0 gaps of 3 cycles, then 03, 04 -> out_data = 32'h04030201, nothing emitted early.
5. Send 2 beats, assert reset asynchronously between edges -> out_valid and cnt drop immediately. Release reset and send 4 beats B1..B4 -> out_data = 32'hB4B3B2B1, with no stale beats included.
6. Nbeats = 1, Nbits = 16: drive 16'hBEEF with out_ready = 0 -> out_valid = 1 and in_ready = 0 until out_ready = 1, then the next beat 16'hCAFE follows back-to-back.
